switchesqsys_nios2_processor_oci_dct_packer: RTL and testbench



---
 rtl/switchesqsys_nios2_oci_trace_pkg.sv | 16 +
 rtl/switchesqsys_nios2_processor_oci_frame_emit.sv | 115 +++++++++++
 rtl/switchesqsys_nios2_processor_oci_dct_packer.sv | 66 ++++++
 tb/tb_switchesqsys_nios2_processor_oci_dct_packer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/switchesqsys_nios2_oci_trace_pkg.sv
// switchesqsys_nios2_oci_trace_pkg: shared constants, frame types and emitter state for the OCI DCT trace packer
package switchesqsys_nios2_oci_trace_pkg;
    localparam int DEF_DCT_DEPTH = 15;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_FRAME_W = 36;
    localparam logic [1:0] FT_DCT_FULL = 2'b00;
    localparam logic [1:0] FT_DCT_PARTIAL = 2'b01;
    localparam logic [1:0] FT_ADDR = 2'b10;
    localparam logic [1:0] FT_OVF = 2'b11;
    localparam logic [1:0] DCT_TAKEN = 2'b01;
    localparam logic [1:0] DCT_NOT_TAKEN = 2'b10;
    typedef enum logic [1:0] {IDLE, SEND_DCT, SEND_ADDR, SEND_OVF} emit_state_t;
    function automatic logic [35:0] addr_frame(input logic [31:0] a);
        return {FT_ADDR, 2'b00, a};
    endfunction
endpackage

// File: rtl/switchesqsys_nios2_processor_oci_frame_emit.sv
// switchesqsys_nios2_processor_oci_frame_emit: holding registers, output FSM and valid/ready handshake
// OCI_DCT_OVF_MARKER_EN adds a dropped-trigger counter reported through an overflow marker frame.
module switchesqsys_nios2_processor_oci_frame_emit
    import switchesqsys_nios2_oci_trace_pkg::*;
#(
    parameter int BUF_W = 2 * DEF_DCT_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int FRAME_W = DEF_FRAME_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trig,
    input  logic               trig_partial,
    input  logic               trig_addr,
    input  logic [3:0]         trig_count,
    input  logic [BUF_W-1:0]   trig_buffer,
    input  logic [ADDR_W-1:0]  trig_addr_val,
    input  logic               frame_ready,
    output logic               frame_valid,
    output logic [FRAME_W-1:0] frame_data,
    output logic               overflow
);
    emit_state_t state;
    logic addr_pend;
    logic [ADDR_W-1:0] hold_addr;
    logic fire, last, free, take, drop, marker;
    logic t_v, t_p, t_a;
    logic [3:0] t_cnt;
    logic [BUF_W-1:0] t_buf;
    logic [ADDR_W-1:0] t_ad;
    assign fire = frame_valid && frame_ready;
    // A trigger coinciding with the final transfer of a sequence is still accepted.
    assign last = fire && (state != SEND_DCT || !addr_pend);
    assign free = state == IDLE || last;
`ifdef OCI_DCT_OVF_MARKER_EN
    logic [15:0] ovf_cnt;
    logic h_v, h_p, h_a;
    logic [3:0] h_cnt;
    logic [BUF_W-1:0] h_buf;
    logic [ADDR_W-1:0] h_ad;
    assign marker = state == IDLE && ovf_cnt != '0;
    assign t_v = h_v || trig;
    assign t_p = h_v ? h_p : trig_partial;
    assign t_a = h_v ? h_a : trig_addr;
    assign t_cnt = h_v ? h_cnt : trig_count;
    assign t_buf = h_v ? h_buf : trig_buffer;
    assign t_ad = h_v ? h_ad : trig_addr_val;
    assign take = t_v && free && !marker;
    assign drop = trig && (h_v || !free);
    // A trigger that loses to the marker waits here instead of being dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt <= '0;
            h_v <= 1'b0;
            {h_p, h_a, h_cnt, h_buf, h_ad} <= '0;
        end else begin
            ovf_cnt <= marker ? '0 : (drop && ovf_cnt != '1) ? ovf_cnt + 16'd1 : ovf_cnt;
            h_v <= (trig && marker) || (h_v && !take);
            if (trig && marker) {h_p, h_a, h_cnt, h_buf, h_ad} <= {trig_partial, trig_addr, trig_count, trig_buffer, trig_addr_val};
        end
    end
`else
    assign marker = 1'b0;
    assign t_v = trig;
    assign t_p = trig_partial;
    assign t_a = trig_addr;
    assign t_cnt = trig_count;
    assign t_buf = trig_buffer;
    assign t_ad = trig_addr_val;
    assign take = trig && free;
    assign drop = trig && !free;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            frame_valid <= 1'b0;
            frame_data <= '0;
            addr_pend <= 1'b0;
            hold_addr <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= overflow || drop;
            if (fire) begin
                if (state == SEND_DCT && addr_pend) begin
                    state <= SEND_ADDR;
                    frame_data <= addr_frame(hold_addr);
                    addr_pend <= 1'b0;
                end else begin
                    state <= IDLE;
                    frame_valid <= 1'b0;
                end
            end
            if (take) begin
                frame_valid <= 1'b1;
                if (t_cnt != 4'd0) begin
                    state <= SEND_DCT;
                    frame_data <= {t_p ? FT_DCT_PARTIAL : FT_DCT_FULL, t_cnt, t_buf};
                    addr_pend <= t_a;
                    hold_addr <= t_ad;
                end else begin
                    state <= SEND_ADDR;
                    frame_data <= addr_frame(t_ad);
                    addr_pend <= 1'b0;
                end
            end
`ifdef OCI_DCT_OVF_MARKER_EN
            if (marker) begin
                state <= SEND_OVF;
                frame_valid <= 1'b1;
                frame_data <= {FT_OVF, 18'b0, ovf_cnt};
            end
`endif
        end
    end
endmodule

// File: rtl/switchesqsys_nios2_processor_oci_dct_packer.sv
// switchesqsys_nios2_processor_oci_dct_packer: accumulates branch outcome codes and triggers trace frames
// Optional overflow marker frames are enabled with OCI_DCT_OVF_MARKER_EN (handled in the frame emitter).
module switchesqsys_nios2_processor_oci_dct_packer
    import switchesqsys_nios2_oci_trace_pkg::*;
#(
    parameter int DCT_DEPTH = DEF_DCT_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int FRAME_W = DEF_FRAME_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trace_en,
    input  logic                   dct_valid,
    input  logic [1:0]             dct_code,
    input  logic                   ind_valid,
    input  logic [ADDR_W-1:0]      ind_addr,
    input  logic                   frame_ready,
    output logic                   frame_valid,
    output logic [FRAME_W-1:0]     frame_data,
    output logic [2*DCT_DEPTH-1:0] dct_buffer,
    output logic [3:0]             dct_count,
    output logic                   overflow
);
    localparam int BUF_W = 2 * DCT_DEPTH;
    localparam logic [3:0] FULL_CNT = 4'(DCT_DEPTH);
    logic trace_en_d, acc, trig_a, trig_b, trig_c, trig;
    logic [BUF_W-1:0] nbuf;
    logic [3:0] ncnt;
    assign acc = trace_en && dct_valid;
    assign nbuf = acc ? {dct_buffer[BUF_W-3:0], dct_code} : dct_buffer;
    assign ncnt = dct_count + {3'b0, acc};
    assign trig_a = acc && ncnt == FULL_CNT;
    assign trig_b = trace_en && ind_valid;
    assign trig_c = trace_en_d && !trace_en && dct_count != 4'd0;
    assign trig = trig_a || trig_b || trig_c;
    // The live buffer clears on every trigger, even one the emitter has to drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_en_d <= 1'b0;
            dct_buffer <= '0;
            dct_count <= '0;
        end else begin
            trace_en_d <= trace_en;
            dct_buffer <= trig ? '0 : nbuf;
            dct_count <= trig ? '0 : ncnt;
        end
    end
    switchesqsys_nios2_processor_oci_frame_emit #(
        .BUF_W(BUF_W),
        .ADDR_W(ADDR_W),
        .FRAME_W(FRAME_W)
    ) u_emit (
        .clk(clk),
        .reset(reset),
        .trig(trig),
        .trig_partial(trig_b || trig_c),
        .trig_addr(trig_b),
        .trig_count(ncnt),
        .trig_buffer(nbuf),
        .trig_addr_val(ind_addr),
        .frame_ready(frame_ready),
        .frame_valid(frame_valid),
        .frame_data(frame_data),
        .overflow(overflow)
    );
endmodule

// File: tb/tb_switchesqsys_nios2_processor_oci_dct_packer.sv
// tb_switchesqsys_nios2_processor_oci_dct_packer: directed and random checks against a frame-queue model
module tb_switchesqsys_nios2_processor_oci_dct_packer;
    import switchesqsys_nios2_oci_trace_pkg::*;
    logic clk = 1'b0;
    logic reset, trace_en, dct_valid, ind_valid, frame_ready;
    logic [1:0] dct_code;
    logic [31:0] ind_addr;
    logic frame_valid, overflow;
    logic [35:0] frame_data;
    logic [29:0] dct_buffer;
    logic [3:0] dct_count;
    int checks = 0;
    int errors = 0;
    logic [1:0] live[$];
    logic [35:0] pend[$];
    bit m_ovf, m_prev_en;

    switchesqsys_nios2_processor_oci_dct_packer dut (
        .clk(clk), .reset(reset), .trace_en(trace_en), .dct_valid(dct_valid),
        .dct_code(dct_code), .ind_valid(ind_valid), .ind_addr(ind_addr),
        .frame_ready(frame_ready), .frame_valid(frame_valid), .frame_data(frame_data),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] dct_frame(input logic [1:0] t, input logic [3:0] n, input logic [29:0] b);
        return {t, n, b};
    endfunction

    function automatic logic [29:0] live_pack();
        logic [29:0] b = '0;
        foreach (live[i]) b = {b[27:0], live[i]};
        return b;
    endfunction

    task automatic compare_all();
        check("frame_valid", {63'b0, frame_valid}, {63'b0, pend.size() > 0});
        if (pend.size() > 0) check("frame_data", {28'b0, frame_data}, {28'b0, pend[0]});
        check("dct_count", {60'b0, dct_count}, 64'(live.size()));
        check("dct_buffer", {34'b0, dct_buffer}, {34'b0, live_pack()});
        check("overflow", {63'b0, overflow}, {63'b0, m_ovf});
    endtask

    // Model: a list of live codes plus a queue of frames still owed downstream.
    task automatic model_update();
        bit full, ind, fall;
        if (reset) begin
            live.delete();
            pend.delete();
            m_ovf = 0;
            m_prev_en = 0;
            return;
        end
        if (pend.size() > 0 && frame_ready) void'(pend.pop_front());
        if (trace_en && dct_valid) live.push_back(dct_code);
        full = trace_en && dct_valid && live.size() == 15;
        ind = trace_en && ind_valid;
        fall = m_prev_en && !trace_en && live.size() > 0;
        if (full || ind || fall) begin
            if (pend.size() == 0) begin
                if (live.size() > 0) pend.push_back(dct_frame((ind || fall) ? FT_DCT_PARTIAL : FT_DCT_FULL, 4'(live.size()), live_pack()));
                if (ind) pend.push_back(addr_frame(ind_addr));
            end else m_ovf = 1;
            live.delete();
        end
        m_prev_en = trace_en;
    endtask

    task automatic cyc(input bit r, input bit en, input bit dv, input logic [1:0] c, input bit iv, input logic [31:0] a, input bit rdy);
        reset = r;
        trace_en = en;
        dct_valid = dv;
        dct_code = c;
        ind_valid = iv;
        ind_addr = a;
        frame_ready = rdy;
        @(negedge clk);
        compare_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; trace_en = 0; dct_valid = 0; dct_code = 0; ind_valid = 0; ind_addr = 0; frame_ready = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_update();
        check("rst_valid", {63'b0, frame_valid}, 64'd0);
        check("rst_data", {28'b0, frame_data}, 64'd0);
        check("rst_count", {60'b0, dct_count}, 64'd0);
        check("rst_buffer", {34'b0, dct_buffer}, 64'd0);
        check("rst_ovf", {63'b0, overflow}, 64'd0);
        // full frame of 15 taken codes
        for (int i = 0; i < 15; i++) cyc(0, 1, 1, DCT_TAKEN, 0, 0, 1);
        check("full_valid", {63'b0, frame_valid}, 64'd1);
        check("full_frame", {28'b0, frame_data}, {28'b0, dct_frame(FT_DCT_FULL, 4'd15, 30'h15555555)});
        check("full_count", {60'b0, dct_count}, 64'd0);
        cyc(0, 1, 0, 0, 0, 0, 1);
        // partial + address
        cyc(0, 1, 1, DCT_TAKEN, 0, 0, 1);
        cyc(0, 1, 1, DCT_NOT_TAKEN, 0, 0, 1);
        cyc(0, 1, 1, DCT_TAKEN, 0, 0, 1);
        cyc(0, 1, 0, 0, 1, 32'h00001234, 1);
        check("part_frame", {28'b0, frame_data}, {28'b0, dct_frame(FT_DCT_PARTIAL, 4'd3, 30'h19)});
        cyc(0, 1, 0, 0, 0, 0, 1);
        check("addr_frame", {28'b0, frame_data}, {28'b0, 2'b10, 2'b00, 32'h00001234});
        cyc(0, 1, 0, 0, 0, 0, 1);
        // address only
        cyc(0, 1, 0, 0, 1, 32'hDEADBEEF, 1);
        check("addr_only", {28'b0, frame_data}, {28'b0, 2'b10, 2'b00, 32'hDEADBEEF});
        cyc(0, 1, 0, 0, 0, 0, 1);
        check("addr_only_end", {63'b0, frame_valid}, 64'd0);
        // overflow while stalled
        for (int i = 0; i < 15; i++) cyc(0, 1, 1, DCT_TAKEN, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(0, 1, 1, DCT_NOT_TAKEN, 0, 0, 0);
        check("ovf_set", {63'b0, overflow}, 64'd1);
        check("ovf_held", {28'b0, frame_data}, {28'b0, dct_frame(FT_DCT_FULL, 4'd15, 30'h15555555)});
        check("ovf_cleared_live", {60'b0, dct_count}, 64'd0);
        cyc(0, 1, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 1);
        check("ovf_no_second", {63'b0, frame_valid}, 64'd0);
        // trace stop flush
        cyc(1, 0, 0, 0, 0, 0, 1);
        check("ovf_reset", {63'b0, overflow}, 64'd0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, DCT_TAKEN, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("stop_frame", {28'b0, frame_data}, {28'b0, dct_frame(FT_DCT_PARTIAL, 4'd5, 30'h155)});
        cyc(0, 0, 1, DCT_TAKEN, 1, 32'h55, 1);
        check("stop_no_addr", {63'b0, frame_valid}, 64'd0);
        check("stop_ignored", {60'b0, dct_count}, 64'd0);
        // count 14 plus coincident code and indirect, then reset mid address frame
        for (int i = 0; i < 14; i++) cyc(0, 1, 1, DCT_TAKEN, 0, 0, 1);
        cyc(0, 1, 1, DCT_NOT_TAKEN, 1, 32'hCAFE0000, 1);
        check("coinc_frame", {28'b0, frame_data}, {28'b0, dct_frame(FT_DCT_PARTIAL, 4'd15, 30'h15555556)});
        cyc(0, 1, 0, 0, 0, 0, 1);
        check("coinc_addr", {28'b0, frame_data}, {28'b0, 2'b10, 2'b00, 32'hCAFE0000});
        cyc(1, 1, 1, DCT_TAKEN, 0, 0, 0);
        check("mid_rst_valid", {63'b0, frame_valid}, 64'd0);
        check("mid_rst_count", {60'b0, dct_count}, 64'd0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0,
                2'($urandom_range(1, 2)), $urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 3) != 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
